// File: rtl/alu_execute_stage_pkg.sv
// Shared constants for the MIPS EX stage: ALU operation codes, forwarding selects
// and default widths. alu_control uses the same ALU code constants.
package alu_execute_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LUI_SHIFT  = 16;

  localparam logic [3:0] ALU_SLL = 4'd0;
  localparam logic [3:0] ALU_SRL = 4'd1;
  localparam logic [3:0] ALU_SRA = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Codes above LUI have no defined operation.
  function automatic logic is_illegal_code(input logic [3:0] code);
    return (code > ALU_LUI);
  endfunction

endpackage

// File: rtl/alu_execute_stage_if.sv
// ID/EX inputs, forwarding/hazard controls and EX/MEM register fields of the EX stage.
interface alu_execute_stage_if
  import alu_execute_stage_pkg::*;
#(
  parameter int DATA_W     = alu_execute_stage_pkg::DATA_W,
  parameter int REG_ADDR_W = alu_execute_stage_pkg::REG_ADDR_W
) ();

  logic [3:0]            alu_code;
  logic                  id_ex_valid;
  logic [DATA_W-1:0]     id_ex_rs_data;
  logic [DATA_W-1:0]     id_ex_rt_data;
  logic [DATA_W-1:0]     id_ex_imm;
  logic [4:0]            id_ex_shamt;
  logic                  id_ex_alu_src;
  logic                  id_ex_shift_var;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  logic                  id_ex_reg_write;
  logic                  id_ex_mem_read;
  logic                  id_ex_mem_write;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic [DATA_W-1:0]     mem_wb_data;
  logic                  stall;
  logic                  flush;

  logic                  ex_mem_valid;
  logic [DATA_W-1:0]     ex_mem_result;
  logic [DATA_W-1:0]     ex_mem_store_data;
  logic [REG_ADDR_W-1:0] ex_mem_rd;
  logic                  ex_mem_reg_write;
  logic                  ex_mem_mem_read;
  logic                  ex_mem_mem_write;
  logic                  ex_mem_zero;
  logic                  ex_mem_illegal;

  modport master (
    output alu_code, id_ex_valid, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_shamt,
           id_ex_alu_src, id_ex_shift_var, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
           id_ex_mem_write, fwd_a, fwd_b, mem_wb_data, stall, flush,
    input  ex_mem_valid, ex_mem_result, ex_mem_store_data, ex_mem_rd, ex_mem_reg_write,
           ex_mem_mem_read, ex_mem_mem_write, ex_mem_zero, ex_mem_illegal
  );

  modport slave (
    input  alu_code, id_ex_valid, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_shamt,
           id_ex_alu_src, id_ex_shift_var, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
           id_ex_mem_write, fwd_a, fwd_b, mem_wb_data, stall, flush,
    output ex_mem_valid, ex_mem_result, ex_mem_store_data, ex_mem_rd, ex_mem_reg_write,
           ex_mem_mem_read, ex_mem_mem_write, ex_mem_zero, ex_mem_illegal
  );

endinterface

// File: rtl/alu_execute_stage_alu_core.sv
// Purely combinational ALU: shifts act on B, LUI is a fixed left shift of B.
module alu_core
  import alu_execute_stage_pkg::*;
#(
  parameter int DATA_W    = alu_execute_stage_pkg::DATA_W,
  parameter int LUI_SHIFT = alu_execute_stage_pkg::LUI_SHIFT
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  input  logic [3:0]        alu_code,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  // Operation select; undefined codes yield zero and raise illegal.
  always_comb begin
    result  = '0;
    illegal = is_illegal_code(alu_code);
    case (alu_code)
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      ALU_SRA: result = $signed(b) >>> shamt;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_LUI: result = b << LUI_SHIFT;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_execute_stage.sv
// MIPS EX stage: operand forwarding, ALU evaluation and the EX/MEM pipeline register
// with hazard-unit stall (hold) and flush (bubble).
module alu_execute_stage
  import alu_execute_stage_pkg::*;
#(
  parameter int DATA_W     = alu_execute_stage_pkg::DATA_W,
  parameter int REG_ADDR_W = alu_execute_stage_pkg::REG_ADDR_W,
  parameter int LUI_SHIFT  = alu_execute_stage_pkg::LUI_SHIFT
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_execute_stage_if.slave bus
);

  logic [DATA_W-1:0]     op_a_s, rt_fwd_s, op_b_s, alu_result_s;
  logic [4:0]            shift_amt_s;
  logic                  alu_illegal_s;

  logic                  valid_d, valid_q;
  logic [DATA_W-1:0]     result_d, result_q;
  logic [DATA_W-1:0]     store_data_d, store_data_q;
  logic [REG_ADDR_W-1:0] rd_d, rd_q;
  logic                  reg_write_d, reg_write_q;
  logic                  mem_read_d, mem_read_q;
  logic                  mem_write_d, mem_write_q;
  logic                  zero_d, zero_q;
  logic                  illegal_d, illegal_q;

  // Forwarding muxes draw on the pre-edge EX/MEM result; select 11 falls back to ID/EX.
  always_comb begin
    case (bus.fwd_a)
      FWD_IDEX:  op_a_s = bus.id_ex_rs_data;
      FWD_WB:    op_a_s = bus.mem_wb_data;
      FWD_EXMEM: op_a_s = result_q;
      default:   op_a_s = bus.id_ex_rs_data;
    endcase
    case (bus.fwd_b)
      FWD_IDEX:  rt_fwd_s = bus.id_ex_rt_data;
      FWD_WB:    rt_fwd_s = bus.mem_wb_data;
      FWD_EXMEM: rt_fwd_s = result_q;
      default:   rt_fwd_s = bus.id_ex_rt_data;
    endcase
    if (bus.id_ex_alu_src) begin
      op_b_s = bus.id_ex_imm;
    end else begin
      op_b_s = rt_fwd_s;
    end
    if (bus.id_ex_shift_var) begin
      shift_amt_s = op_a_s[4:0];
    end else begin
      shift_amt_s = bus.id_ex_shamt;
    end
  end

  alu_core #(
    .DATA_W    (DATA_W),
    .LUI_SHIFT (LUI_SHIFT)
  ) u_alu_core (
    .a        (op_a_s),
    .b        (op_b_s),
    .shamt    (shift_amt_s),
    .alu_code (bus.alu_code),
    .result   (alu_result_s),
    .illegal  (alu_illegal_s)
  );

  // EX/MEM next state: flush > stall > load; an invalid instruction loads a bubble like flush.
  always_comb begin
    valid_d      = valid_q;
    result_d     = result_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    zero_d       = zero_q;
    illegal_d    = illegal_q;
    if (bus.flush || (!bus.stall && !bus.id_ex_valid)) begin
      valid_d      = 1'b0;
      result_d     = '0;
      store_data_d = '0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      zero_d       = 1'b0;
      illegal_d    = 1'b0;
    end else if (!bus.stall) begin
      valid_d      = 1'b1;
      result_d     = alu_result_s;
      store_data_d = rt_fwd_s;
      rd_d         = bus.id_ex_rd;
      reg_write_d  = bus.id_ex_reg_write;
      mem_read_d   = bus.id_ex_mem_read;
      mem_write_d  = bus.id_ex_mem_write;
      zero_d       = (alu_result_s == '0);
      illegal_d    = alu_illegal_s;
    end else begin
      valid_d = valid_q;
    end
  end

  // EX/MEM pipeline register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      result_q     <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      zero_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      result_q     <= result_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      zero_q       <= zero_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.ex_mem_valid      = valid_q;
  assign bus.ex_mem_result     = result_q;
  assign bus.ex_mem_store_data = store_data_q;
  assign bus.ex_mem_rd         = rd_q;
  assign bus.ex_mem_reg_write  = reg_write_q;
  assign bus.ex_mem_mem_read   = mem_read_q;
  assign bus.ex_mem_mem_write  = mem_write_q;
  assign bus.ex_mem_zero       = zero_q;
  assign bus.ex_mem_illegal    = illegal_q;

endmodule
